// File: rtl/uart_arb_pkg.sv
// Shared definitions for the uart_tx_arbiter slice.
// Contents:
//   state_e          - FSM state encoding (IDLE / TAG / DATA)
//   TAG_BASE_DEFAULT - default base value of the channel tag byte (ASCII '0')
//   tag_byte()       - tag value for a granted channel index
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TAG  = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    localparam logic [7:0] TAG_BASE_DEFAULT = 8'h30;

    // Tag identifying the source channel on the serial line; wraps modulo 256.
    function automatic logic [7:0] tag_byte(input logic [7:0] base, input logic [7:0] idx);
        return base + idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: returns the first set request bit found when
// searching upward from the pointer, wrapping past NUM_REQ-1 back to 0.
// Ports:
//   req_i   - request vector
//   ptr_i   - index with the highest priority this cycle
//   grant_o - one-hot winner (0 when no request)
//   idx_o   - binary index of the winner
//   valid_o - at least one request present
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    int             pos;
    logic [IDX_W-1:0] pos_idx;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // Walk positions ptr, ptr+1, ... modulo NUM_REQ; first hit wins.
            pos = int'(ptr_i) + i;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            pos_idx = IDX_W'(pos);
            if (!valid_o && req_i[pos_idx]) begin
                valid_o          = 1'b1;
                idx_o            = pos_idx;
                grant_o[pos_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-level round-robin arbiter sharing one uart_tx byte sink between
// NUM_REQ requesters. A grant covers a whole message (ended by the owner's
// last flag) or at most MAX_BURST payload bytes, and optionally starts with a
// tag byte TAG_BASE + owner index.
// Ports:
//   i_clk, i_rst   - clock, synchronous active-high reset
//   i_req_data     - byte of requester k at [8k+7:8k]
//   i_req_valid    - requester k presents a byte
//   i_req_last     - requester k's byte ends its message
//   o_req_ready    - byte of requester k accepted when valid & ready
//   o_tx_data      - byte to uart_tx
//   o_tx_valid     - byte valid to uart_tx
//   i_tx_ready     - uart_tx can take a byte
//   o_grant        - one-hot current owner, 0 when idle
//   o_busy         - a grant is in progress
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int         NUM_REQ   = 4,
    parameter int         MAX_BURST = 64,
    parameter bit         TAG_EN    = 1'b1,
    parameter logic [7:0] TAG_BASE  = TAG_BASE_DEFAULT
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [8*NUM_REQ-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    input  logic [NUM_REQ-1:0]   i_req_last,
    output logic [NUM_REQ-1:0]   o_req_ready,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_valid,
    input  logic                 i_tx_ready,
    output logic [NUM_REQ-1:0]   o_grant,
    output logic                 o_busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

    state_e             state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   ptr_d;
    logic [CNT_W-1:0]   burst_q;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;

    logic [7:0]         own_data;
    logic               own_valid;
    logic               own_last;
    logic               tx_fire;
    logic               burst_end;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_i   (i_req_valid),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Owner's byte stream, selected by the registered grant index.
    assign own_data  = i_req_data[{idx_q, 3'b000} +: 8];
    assign own_valid = i_req_valid[idx_q];
    assign own_last  = i_req_last[idx_q];

    assign tx_fire = o_tx_valid & i_tx_ready;

    // Byte being transferred now is the MAX_BURST-th of this grant.
    assign burst_end = (MAX_BURST != 0) && ((int'(burst_q) + 1) == MAX_BURST);

    // Priority moves to the requester after the winner, wrapping at the top.
    assign ptr_d = (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + IDX_W'(1);

    assign o_grant = grant_q;
    assign o_busy  = (state_q != ST_IDLE);

    // The DATA path is a straight combinational pass-through so the owner sees
    // uart_tx's ready in the same cycle.
    always_comb begin
        o_tx_valid  = 1'b0;
        o_tx_data   = 8'h00;
        o_req_ready = '0;
        case (state_q)
            ST_TAG: begin
                o_tx_valid = 1'b1;
                o_tx_data  = tag_byte(TAG_BASE, 8'(idx_q));
            end
            ST_DATA: begin
                o_tx_valid  = own_valid;
                o_tx_data   = own_data;
                o_req_ready = grant_q & {NUM_REQ{i_tx_ready}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            burst_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arb_valid) begin
                        grant_q <= arb_grant;
                        idx_q   <= arb_idx;
                        ptr_q   <= ptr_d;
                        burst_q <= '0;
                        state_q <= TAG_EN ? ST_TAG : ST_DATA;
                    end
                end
                ST_TAG: begin
                    if (i_tx_ready) begin
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tx_fire) begin
                        burst_q <= burst_q + CNT_W'(1);
                        // Last byte and burst limit on the same byte release once.
                        if (own_last || burst_end) begin
                            state_q <= ST_IDLE;
                            grant_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int MB   = 3;

    logic          clk;
    logic          rst;
    logic [31:0]   req_data;
    logic [3:0]    req_valid;
    logic [3:0]    req_last;
    logic [3:0]    req_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [3:0]    grant;
    logic          busy;

    int checks;
    int failures;
    int grants;

    // Per-requester byte queues: {last, data}
    logic [8:0] mem [NREQ][64];
    int         head [NREQ];
    int         tail [NREQ];

    logic [7:0] exp_d[$];
    int         exp_o[$];
    logic [7:0] obs_d[$];
    int         obs_o[$];

    typedef struct {
        logic [3:0]  v;
        logic [31:0] d;
        logic [3:0]  l;
        logic [17:0] e;
    } vec_t;

    vec_t tbl[16];

    uart_tx_arbiter #(
        .NUM_REQ   (NREQ),
        .MAX_BURST (MB),
        .TAG_EN    (1'b1),
        .TAG_BASE  (8'h30)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_data  (req_data),
        .i_req_valid (req_valid),
        .i_req_last  (req_last),
        .o_req_ready (req_ready),
        .o_tx_data   (tx_data),
        .o_tx_valid  (tx_valid),
        .i_tx_ready  (tx_ready),
        .o_grant     (grant),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] pk(input logic tv, input logic [7:0] td, input logic [3:0] g,
                                       input logic b, input logic [3:0] rr);
        return {tv, tv ? td : 8'h00, g, b, rr};
    endfunction

    function automatic logic [17:0] outs();
        return {tx_valid, tx_valid ? tx_data : 8'h00, grant, busy, req_ready};
    endfunction

    function automatic int oh2idx(input logic [3:0] g);
        if ($countones(g) != 1) return -1;
        for (int i = 0; i < NREQ; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l, input logic r);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = v;
        req_data  = d;
        req_last  = l;
        tx_ready  = r;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        tx_ready  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_outs", 32'(outs()), 32'(pk(0, 8'h00, 4'b0000, 0, 4'b0000)));
    endtask

    task automatic clear_q();
        for (int k = 0; k < NREQ; k++) begin
            head[k] = 0;
            tail[k] = 0;
        end
    endtask

    task automatic push_byte(input int k, input logic [7:0] d, input logic l);
        mem[k][tail[k]] = {l, d};
        tail[k]++;
    endtask

    // Reference: from pointer 0, each grant goes to the first requester at or
    // after the pointer with bytes pending; it emits the tag, then bytes until
    // a last flag or MB bytes, whichever comes first.
    task automatic build_expected();
        int h[NREQ];
        int p;
        int w;
        int cnt;
        logic done;
        logic [8:0] b;
        exp_d.delete();
        exp_o.delete();
        for (int k = 0; k < NREQ; k++) h[k] = head[k];
        p = 0;
        while (1) begin
            w = -1;
            for (int i = 0; i < NREQ; i++) begin
                int k;
                k = (p + i) % NREQ;
                if (w < 0 && h[k] < tail[k]) w = k;
            end
            if (w < 0) break;
            p = (w + 1) % NREQ;
            exp_d.push_back(8'h30 + 8'(w));
            exp_o.push_back(w);
            cnt  = 0;
            done = 1'b0;
            while (!done && h[w] < tail[w]) begin
                b = mem[w][h[w]];
                h[w]++;
                cnt++;
                exp_d.push_back(b[7:0]);
                exp_o.push_back(w);
                done = b[8] || (MB != 0 && cnt == MB);
            end
        end
    endtask

    // Presents queued bytes, models the downstream sink (mode 0: always ready,
    // 1: random, 2: ready only after 80 idle cycles) and records transfers.
    task automatic run_engine(input int mode, input int drop_pct, input int budget);
        int   cyc;
        int   stall_cnt;
        logic prev_stall;
        logic [7:0] prev_data;
        logic [3:0] prev_g;
        logic empty;
        logic finished;
        obs_d.delete();
        obs_o.delete();
        grants     = 0;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        prev_g     = '0;
        stall_cnt  = 0;
        finished   = 1'b0;
        for (cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            rst = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                if (head[k] < tail[k]) begin
                    req_valid[k]      = 1'b1;
                    req_data[8*k +: 8] = mem[k][head[k]][7:0];
                    req_last[k]       = mem[k][head[k]][8];
                end else begin
                    req_valid[k]      = 1'b0;
                    req_data[8*k +: 8] = 8'($urandom);
                    req_last[k]       = 1'($urandom);
                end
                if (grant[k] && !prev_stall && $urandom_range(0, 99) < drop_pct) req_valid[k] = 1'b0;
            end
            case (mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ($urandom_range(0, 2) != 0);
                default: tx_ready = (stall_cnt >= 80);
            endcase
            stall_cnt++;
            #1;
            chk("ready_leak", 32'(req_ready & ~grant), 32'h0);
            if (prev_stall) chk("tx_hold", 32'({tx_valid, tx_data}), 32'({1'b1, prev_data}));
            if (grant != 4'b0000 && prev_g == 4'b0000) grants++;
            prev_g = grant;
            if (tx_valid && tx_ready) begin
                obs_d.push_back(tx_data);
                obs_o.push_back(oh2idx(grant));
                stall_cnt = 0;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            for (int k = 0; k < NREQ; k++) if (req_valid[k] && req_ready[k]) head[k]++;
            empty = 1'b1;
            for (int k = 0; k < NREQ; k++) if (head[k] < tail[k]) empty = 1'b0;
            if (empty && !busy && !tx_valid) begin
                finished = 1'b1;
                break;
            end
        end
        chk("engine_done", 32'(finished), 32'h1);
    endtask

    task automatic cmp_stream(input string tag);
        chk({tag, "_len"}, 32'(obs_d.size()), 32'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i), 32'(obs_d[i]), 32'(exp_d[i]));
            chk($sformatf("%s_owner%0d", tag, i), 32'(obs_o[i]), 32'(exp_o[i]));
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        grants    = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b0;

        // Cycle-by-cycle vectors, ready always high, starting from reset.
        // Rows 0-5: req0 message 41 42 43 (last and burst limit coincide on 43).
        // Rows 6-15: req1/req2 contend, then req1 wins again via wrap.
        tbl[0]  = '{4'b0001, 32'h00000041, 4'b0000, pk(0, 8'h00, 4'b0000, 0, 4'b0000)};
        tbl[1]  = '{4'b0001, 32'h00000041, 4'b0000, pk(1, 8'h30, 4'b0001, 1, 4'b0000)};
        tbl[2]  = '{4'b0001, 32'h00000041, 4'b0000, pk(1, 8'h41, 4'b0001, 1, 4'b0001)};
        tbl[3]  = '{4'b0001, 32'h00000042, 4'b0000, pk(1, 8'h42, 4'b0001, 1, 4'b0001)};
        tbl[4]  = '{4'b0001, 32'h00000043, 4'b0001, pk(1, 8'h43, 4'b0001, 1, 4'b0001)};
        tbl[5]  = '{4'b0000, 32'h00000000, 4'b0000, pk(0, 8'h00, 4'b0000, 0, 4'b0000)};
        tbl[6]  = '{4'b0110, 32'h00B2A100, 4'b0110, pk(0, 8'h00, 4'b0000, 0, 4'b0000)};
        tbl[7]  = '{4'b0110, 32'h00B2A100, 4'b0110, pk(1, 8'h31, 4'b0010, 1, 4'b0000)};
        tbl[8]  = '{4'b0110, 32'h00B2A100, 4'b0110, pk(1, 8'hA1, 4'b0010, 1, 4'b0010)};
        tbl[9]  = '{4'b0100, 32'h00B20000, 4'b0100, pk(0, 8'h00, 4'b0000, 0, 4'b0000)};
        tbl[10] = '{4'b0100, 32'h00B20000, 4'b0100, pk(1, 8'h32, 4'b0100, 1, 4'b0000)};
        tbl[11] = '{4'b0100, 32'h00B20000, 4'b0100, pk(1, 8'hB2, 4'b0100, 1, 4'b0100)};
        tbl[12] = '{4'b0010, 32'h0000C100, 4'b0010, pk(0, 8'h00, 4'b0000, 0, 4'b0000)};
        tbl[13] = '{4'b0010, 32'h0000C100, 4'b0010, pk(1, 8'h31, 4'b0010, 1, 4'b0000)};
        tbl[14] = '{4'b0010, 32'h0000C100, 4'b0010, pk(1, 8'hC1, 4'b0010, 1, 4'b0010)};
        tbl[15] = '{4'b0000, 32'h00000000, 4'b0000, pk(0, 8'h00, 4'b0000, 0, 4'b0000)};

        repeat (2) @(negedge clk);
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].l, 1'b1);
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].e));
        end

        // Owner req2 stalls its valid for 10 cycles while req0 waits.
        do_reset();
        drive(4'b0100, 32'h00D00000, 4'b0000, 1'b1);
        chk("drop_idle", 32'(outs()), 32'(pk(0, 8'h00, 4'b0000, 0, 4'b0000)));
        drive(4'b0101, 32'h00D000E0, 4'b0001, 1'b1);
        chk("drop_tag", 32'(outs()), 32'(pk(1, 8'h32, 4'b0100, 1, 4'b0000)));
        drive(4'b0101, 32'h00D000E0, 4'b0001, 1'b1);
        chk("drop_d0", 32'(outs()), 32'(pk(1, 8'hD0, 4'b0100, 1, 4'b0100)));
        drive(4'b0101, 32'h00D100E0, 4'b0001, 1'b1);
        chk("drop_d1", 32'(outs()), 32'(pk(1, 8'hD1, 4'b0100, 1, 4'b0100)));
        for (int i = 0; i < 10; i++) begin
            drive(4'b0001, 32'h00D200E0, 4'b0001, 1'b1);
            chk($sformatf("drop_hold%0d", i), 32'(outs()), 32'(pk(0, 8'h00, 4'b0100, 1, 4'b0100)));
        end
        drive(4'b0101, 32'h00D200E0, 4'b0101, 1'b1);
        chk("drop_d2", 32'(outs()), 32'(pk(1, 8'hD2, 4'b0100, 1, 4'b0100)));
        drive(4'b0001, 32'h000000E0, 4'b0001, 1'b1);
        chk("drop_idle2", 32'(outs()), 32'(pk(0, 8'h00, 4'b0000, 0, 4'b0000)));
        drive(4'b0001, 32'h000000E0, 4'b0001, 1'b1);
        chk("drop_tag0", 32'(outs()), 32'(pk(1, 8'h30, 4'b0001, 1, 4'b0000)));
        drive(4'b0001, 32'h000000E0, 4'b0001, 1'b1);
        chk("drop_e0", 32'(outs()), 32'(pk(1, 8'hE0, 4'b0001, 1, 4'b0001)));
        drive(4'b0000, 32'h00000000, 4'b0000, 1'b1);
        chk("drop_end", 32'(outs()), 32'(pk(0, 8'h00, 4'b0000, 0, 4'b0000)));

        // Reset in DATA after two bytes; pointer must restart at 0 (req1 beats req2).
        do_reset();
        drive(4'b0010, 32'h0000F000, 4'b0000, 1'b1);
        chk("rst_idle", 32'(outs()), 32'(pk(0, 8'h00, 4'b0000, 0, 4'b0000)));
        drive(4'b0010, 32'h0000F000, 4'b0000, 1'b1);
        chk("rst_tag", 32'(outs()), 32'(pk(1, 8'h31, 4'b0010, 1, 4'b0000)));
        drive(4'b0010, 32'h0000F000, 4'b0000, 1'b1);
        chk("rst_f0", 32'(outs()), 32'(pk(1, 8'hF0, 4'b0010, 1, 4'b0010)));
        drive(4'b0010, 32'h0000F100, 4'b0000, 1'b1);
        chk("rst_f1", 32'(outs()), 32'(pk(1, 8'hF1, 4'b0010, 1, 4'b0010)));
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 4'b0000;
        drive(4'b0110, 32'h00C2C100, 4'b0110, 1'b1);
        chk("rst_mid", 32'(outs()), 32'(pk(0, 8'h00, 4'b0000, 0, 4'b0000)));
        drive(4'b0110, 32'h00C2C100, 4'b0110, 1'b1);
        chk("rst_rearb", 32'(outs()), 32'(pk(1, 8'h31, 4'b0010, 1, 4'b0000)));
        drive(4'b0110, 32'h00C2C100, 4'b0110, 1'b1);
        chk("rst_c1", 32'(outs()), 32'(pk(1, 8'hC1, 4'b0010, 1, 4'b0010)));
        drive(4'b0000, 32'h00000000, 4'b0000, 1'b1);
        chk("rst_end", 32'(outs()), 32'(pk(0, 8'h00, 4'b0000, 0, 4'b0000)));

        // Burst limit 3: req3 sends 5 bytes, fragmented into two grants.
        do_reset();
        clear_q();
        push_byte(3, 8'h51, 1'b0);
        push_byte(3, 8'h52, 1'b0);
        push_byte(3, 8'h53, 1'b0);
        push_byte(3, 8'h54, 1'b0);
        push_byte(3, 8'h55, 1'b1);
        exp_d = '{8'h33, 8'h51, 8'h52, 8'h53, 8'h33, 8'h54, 8'h55};
        exp_o = '{3, 3, 3, 3, 3, 3, 3};
        run_engine(0, 0, 500);
        cmp_stream("burst");
        chk("burst_grants", 32'(grants), 32'd2);

        // Slow sink: ready low 80 cycles per byte.
        do_reset();
        clear_q();
        push_byte(0, 8'h61, 1'b0);
        push_byte(0, 8'h62, 1'b1);
        push_byte(2, 8'h71, 1'b1);
        exp_d = '{8'h30, 8'h61, 8'h62, 8'h32, 8'h71};
        exp_o = '{0, 0, 0, 2, 2};
        run_engine(2, 0, 3000);
        cmp_stream("slow");
        chk("slow_grants", 32'(grants), 32'd2);

        // Randomized traffic against the message-level reference.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            clear_q();
            for (int k = 0; k < NREQ; k++) begin
                int nmsg;
                nmsg = $urandom_range(0, 3);
                for (int m = 0; m < nmsg; m++) begin
                    int len;
                    len = $urandom_range(1, 6);
                    for (int b = 0; b < len; b++) push_byte(k, 8'($urandom), (b == len - 1));
                end
            end
            build_expected();
            run_engine(1, 12, 6000);
            cmp_stream($sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Message-level round-robin arbiter that shares one uart_tx byte sink between NUM_REQ requesters (e.g. CPU console, debug monitor, status emitter).
A grant is held for a whole message, terminated by the requester's last flag or by a burst limit.
Each grant optionally starts with an internally generated tag byte that identifies the source channel on the serial line.
The block sits directly upstream of uart_tx: o_tx_data/o_tx_valid/i_tx_ready connect to i_data/i_valid/o_ready.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MAX_BURST, 64, max payload bytes per grant; 0 = unlimited
TAG_EN, 1, 1 = emit tag byte before first payload byte of each grant
TAG_BASE, 8'h30, tag byte value = TAG_BASE + granted index (ASCII '0'..)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_req_data  in  8*NUM_REQ  byte from requester k at [8k+7:8k]
i_req_valid  in  NUM_REQ  requester k has a byte
i_req_last  in  NUM_REQ  byte from k is the final byte of its message
o_req_ready  out  NUM_REQ  byte from k accepted this cycle when valid&ready
o_tx_data  out  8  byte to uart_tx
o_tx_valid  out  1  byte valid to uart_tx
i_tx_ready  in  1  uart_tx ready
o_grant  out  NUM_REQ  one-hot current owner; 0 when idle
o_busy  out  1  state != IDLE

Behaviour:
- Reset is decided: reset i_rst, synchronous, active-high; clock i_clk.
- Reset values: state IDLE, o_grant 0, rr pointer 0, burst count 0, o_busy 0, o_tx_valid 0, o_req_ready 0.
- Reset mid-message aborts the grant with no completion. A byte already accepted by uart_tx finishes serialising there.
- Downstream transfer occurs when o_tx_valid & i_tx_ready at a clock edge. Upstream transfer for k occurs when i_req_valid[k] & o_req_ready[k].
- States: IDLE, TAG, DATA.
- IDLE:
  - o_tx_valid = 0, o_req_ready = 0.
  - If any i_req_valid, pick the first set bit searching from pointer upward, with wrap.
  - Register o_grant and set pointer = (winner+1) mod NUM_REQ.
  - Next state is TAG if TAG_EN, else DATA. Clear burst count.
- TAG:
  - o_tx_valid = 1, o_tx_data = TAG_BASE + idx, o_req_ready = 0.
  - On transfer, go to DATA.
- DATA:
  - o_tx_data = i_req_data of the granted slice; o_tx_valid = i_req_valid[g].
  - o_req_ready[g] = i_tx_ready; all other ready bits are 0. This path is combinational.
  - On each transfer, burst count increments (width $clog2(MAX_BURST+1)).
  - Go to IDLE if i_req_last[g] is set, or if MAX_BURST != 0 and burst count+1 == MAX_BURST. The latter is a fragmented message; the owner re-arbitrates and gets a fresh tag.
- Latency: valid at cycle t in IDLE -> o_grant and o_tx_valid at t+1. At least one IDLE cycle separates consecutive grants, including to the same requester.
- Owner deasserts valid mid-message: grant is held, o_tx_valid = 0, no timeout.
- Non-granted requesters never see ready. Their valid/data may change freely.
- i_tx_ready low: o_tx_data/o_tx_valid stay stable in TAG. In DATA they mirror the owner, which must hold its data per valid/ready rules.
- Simultaneous last and burst limit on the same byte: single release, counted once.
- NUM_REQ = 1: pointer stays 0, behaviour is otherwise identical.

Decomposition:
- Package uart_arb_pkg: state encoding localparams (ST_IDLE = 2'd0, ST_TAG = 2'd1, ST_DATA = 2'd2), default TAG_BASE.
- Sub-module rr_arbiter: NUM_REQ request vector plus pointer in, one-hot grant out, purely combinational. The pointer register lives in the parent.

Test Plan:
- TAG_EN=1, req0 sends 8'h41, 8'h42, 8'h43 (last on 8'h43), i_tx_ready=1 -> tx sequence 8'h30, 8'h41, 8'h42, 8'h43; o_grant = 4'b0001 for 4 cycles, then 0; o_busy drops after the last transfer.
- req1 and req2 valid in the same cycle, single-byte messages, pointer 0 -> tx 8'h31, byte1, IDLE, 8'h32, byte2; then req1 again -> next grant goes to req1 via wrap after req2.
- MAX_BURST=2, req3 sends 5 bytes with last on the 5th -> tags precede bytes 1, 3 and 5 (8'h33 each); grant re-issued 3 times.
- Connect real uart_tx (clk_freq_hz/baud_rate = 8): tx ready low for 80 cycles per byte -> o_tx_data stable while ready is low; decoded serial bytes match the sent sequence.
- Owner drops valid for 10 cycles mid-message while req0 is valid -> o_grant unchanged, o_tx_valid 0, no req0 ready; message resumes and completes.
- Assert i_rst in DATA after 2 bytes -> next cycle all outputs at reset values, pointer 0; subsequent request arbitrates normally.
